// File: rtl/distributor_q_pkg.sv
// Shared types and width helpers for the work distributor and its channel queues.
package distributor_q_pkg;

  typedef enum logic [1:0] {
    SEL_RR    = 2'd0,
    SEL_BCAST = 2'd1,
    SEL_ADDR  = 2'd2
  } sel_mode_e;

  // Index width for n entries; never zero so single-entry cases still get a real port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/distributor_q_chan_fifo.sv
// Per-channel first-word-fall-through queue: register array, wrapping pointers, occupancy count.
module distributor_chan_fifo
  import distributor_q_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             wr_en_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             empty_nxt_o,
  output logic             nfull_o
);

  localparam int PW = idx_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             empty_q;
  logic             push, pop;

  always_comb begin
    push     = wr_en_i;
    pop      = rd_en_i & ~empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= (count_d == '0);
    end
  end

  // Storage needs no reset: contents are only visible while the count says they are valid.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o      = mem_q[rd_ptr_q];
  assign empty_o     = empty_q;
  assign empty_nxt_o = (count_d == '0);
  assign nfull_o     = (count_q != CW'(DEPTH));

endmodule

// File: rtl/distributor_q.sv
// Work distributor: routes one upstream item stream to N channel queues (round-robin, broadcast, addressed).
module distributor_q
  import distributor_q_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int N         = 4,
  parameter int DEPTH     = 2,
  parameter int SKIP_FULL = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [WIDTH-1:0]      din_i,
  input  logic                  wr_en_i,
  input  logic                  bcast_i,
  input  logic                  addr_en_i,
  input  logic [idx_w(N)-1:0]   addr_i,
  output logic                  full_o,
  output logic [WIDTH*N-1:0]    dout_o,
  input  logic [N-1:0]          rd_en_i,
  output logic [N-1:0]          empty_o,
  output logic                  idle_o
);

  localparam int AW = idx_w(N);

  logic [N-1:0]  nfull, empty_nxt, push_mask, push_vec;
  logic [AW-1:0] next_r_q, next_r_d, rr_sel;
  logic          rr_found, full, accept, idle_q;
  sel_mode_e     mode;

  assign mode = bcast_i ? SEL_BCAST : (addr_en_i ? SEL_ADDR : SEL_RR);

  // Lowest cyclic offset from next_r wins, hence the descending scan.
  always_comb begin
    rr_found = 1'b0;
    rr_sel   = next_r_q;
    if (SKIP_FULL != 0) begin
      for (int k = N - 1; k >= 0; k--) begin
        if (nfull[(int'(next_r_q) + k) % N]) begin
          rr_found = 1'b1;
          rr_sel   = AW'((int'(next_r_q) + k) % N);
        end
      end
    end else begin
      rr_found = nfull[next_r_q];
    end
  end

  always_comb begin
    full      = 1'b1;
    push_mask = '0;
    case (mode)
      SEL_BCAST: begin
        full      = ~&nfull;
        push_mask = '1;
      end
      SEL_ADDR: begin
        if (int'(addr_i) < N) begin
          full              = ~nfull[addr_i];
          push_mask[addr_i] = 1'b1;
        end
      end
      default: begin
        full              = ~rr_found;
        push_mask[rr_sel] = 1'b1;
      end
    endcase
    accept   = wr_en_i & ~full;
    push_vec = push_mask & {N{accept}};
  end

  always_comb begin
    next_r_d = next_r_q;
    if (accept && mode == SEL_RR)
      next_r_d = (int'(rr_sel) == N - 1) ? '0 : rr_sel + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      next_r_q <= '0;
      idle_q   <= 1'b1;
    end else begin
      next_r_q <= next_r_d;
      idle_q   <= &empty_nxt;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_chan
    distributor_chan_fifo #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .din_i      (din_i),
      .wr_en_i    (push_vec[i]),
      .rd_en_i    (rd_en_i[i]),
      .dout_o     (dout_o[WIDTH*i +: WIDTH]),
      .empty_o    (empty_o[i]),
      .empty_nxt_o(empty_nxt[i]),
      .nfull_o    (nfull[i])
    );
  end

  assign full_o = full;
  assign idle_o = idle_q;

endmodule

// File: tb/tb_distributor_q.sv
// Bench for distributor_q: skip-full and strict-rotation instances driven in lockstep against queue models.
module tb_distributor_q;

  localparam int W = 64;
  localparam int NC = 4;
  localparam int DP = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  din;
  logic          wr_en, bcast, addr_en;
  logic [1:0]    addr;
  logic [NC-1:0] rd_en;

  logic          full_w  [2];
  logic [W*NC-1:0] dout_w [2];
  logic [NC-1:0] empty_w [2];
  logic          idle_w  [2];

  int n_cmp = 0;
  int n_bad = 0;

  // Model: one queue per channel per instance, plus the round-robin pointer.
  logic [W-1:0] mq [2][NC][$];
  int           nr [2];

  always #5 clk = ~clk;

  distributor_q #(.WIDTH(W), .N(NC), .DEPTH(DP), .SKIP_FULL(1)) dut0 (
    .clk_i(clk), .rst_i(rst), .din_i(din), .wr_en_i(wr_en), .bcast_i(bcast),
    .addr_en_i(addr_en), .addr_i(addr), .full_o(full_w[0]), .dout_o(dout_w[0]),
    .rd_en_i(rd_en), .empty_o(empty_w[0]), .idle_o(idle_w[0]));

  distributor_q #(.WIDTH(W), .N(NC), .DEPTH(DP), .SKIP_FULL(0)) dut1 (
    .clk_i(clk), .rst_i(rst), .din_i(din), .wr_en_i(wr_en), .bcast_i(bcast),
    .addr_en_i(addr_en), .addr_i(addr), .full_o(full_w[1]), .dout_o(dout_w[1]),
    .rd_en_i(rd_en), .empty_o(empty_w[1]), .idle_o(idle_w[1]));

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int m_rr_target(int d);
    if (d == 0) begin
      for (int k = 0; k < NC; k++)
        if (mq[d][(nr[d] + k) % NC].size() < DP) return (nr[d] + k) % NC;
      return -1;
    end
    return (mq[d][nr[d]].size() < DP) ? nr[d] : -1;
  endfunction

  function automatic bit m_full(int d);
    bit f;
    f = 1'b0;
    if (bcast) begin
      for (int c = 0; c < NC; c++) if (mq[d][c].size() == DP) f = 1'b1;
    end else if (addr_en) begin
      f = (mq[d][addr].size() == DP);
    end else begin
      f = (m_rr_target(d) < 0);
    end
    return f;
  endfunction

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < NC; c++) mq[d][c].delete();
      nr[d] = 0;
    end
  endtask

  task automatic m_clock();
    for (int d = 0; d < 2; d++) begin
      bit f;
      bit pop [NC];
      int t;
      f = m_full(d);
      t = m_rr_target(d);
      for (int c = 0; c < NC; c++) pop[c] = rd_en[c] && (mq[d][c].size() > 0);
      for (int c = 0; c < NC; c++) if (pop[c]) void'(mq[d][c].pop_front());
      if (wr_en && !f) begin
        if (bcast) begin
          for (int c = 0; c < NC; c++) mq[d][c].push_back(din);
        end else if (addr_en) begin
          mq[d][addr].push_back(din);
        end else begin
          mq[d][t].push_back(din);
          nr[d] = (t + 1) % NC;
        end
      end
    end
  endtask

  task automatic compare();
    for (int d = 0; d < 2; d++) begin
      logic [NC-1:0] e;
      for (int c = 0; c < NC; c++) e[c] = (mq[d][c].size() == 0);
      chk($sformatf("full[%0d]", d), W'(full_w[d]), W'(m_full(d)));
      chk($sformatf("empty[%0d]", d), W'(empty_w[d]), W'(e));
      chk($sformatf("idle[%0d]", d), W'(idle_w[d]), W'(&e));
      for (int c = 0; c < NC; c++)
        if (mq[d][c].size() > 0)
          chk($sformatf("dout[%0d].ch%0d", d, c), dout_w[d][c*W +: W], mq[d][c][0]);
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    if (!rst) m_clock();
    #1;
  endtask

  task automatic idle_in();
    wr_en = 0; bcast = 0; addr_en = 0; addr = 0; rd_en = '0;
  endtask

  initial begin
    rst = 1'b1; din = '0;
    idle_in();
    m_reset();
    #3;
    chk("reset_empty", W'(empty_w[0]), W'(4'b1111));
    chk("reset_idle", W'(idle_w[0]), W'(1'b1));
    chk("reset_full", W'(full_w[0]), W'(1'b0));
    step(); step();
    rst = 1'b0;

    // Round-robin A..D lands in channels 0..3.
    for (int i = 0; i < NC; i++) begin
      din = W'(64'hA + i); wr_en = 1;
      step();
    end
    idle_in();
    for (int c = 0; c < NC; c++)
      chk($sformatf("rr_head%0d", c), dout_w[0][c*W +: W], W'(64'hA + c));
    chk("rr_ptr_model", W'(nr[0]), W'(0));

    rd_en = 4'hF; step(); idle_in();
    din = 64'h11; wr_en = 1; step(); idle_in();
    rd_en = 4'b0001; step(); idle_in();
    addr_en = 1; addr = 1; wr_en = 1; din = 64'h21; step();
    din = 64'h22; step(); idle_in();

    // ch1 full, next_r=1: skip-full goes to ch2, strict rotation blocks.
    wr_en = 1; din = 64'h55; #1;
    chk("skip_full_free", W'(full_w[0]), W'(1'b0));
    chk("strict_full", W'(full_w[1]), W'(1'b1));
    step();
    chk("skip_lands_ch2", dout_w[0][2*W +: W], W'(64'h55));
    chk("skip_ptr_model", W'(nr[0]), W'(3));
    rd_en = 4'b0010; #1;
    chk("strict_full_during_pop", W'(full_w[1]), W'(1'b1));
    step();
    rd_en = '0; #1;
    chk("strict_free_after_pop", W'(full_w[1]), W'(1'b0));
    step(); idle_in();
    chk("strict_ch1_head", dout_w[1][1*W +: W], W'(64'h22));

    // Broadcast blocked by a full ch3, then accepted once it drains.
    addr_en = 1; addr = 3; wr_en = 1; din = 64'h33; step(); idle_in();
    bcast = 1; wr_en = 1; din = 64'h77; #1;
    chk("bcast_blocked", W'(full_w[0]), W'(1'b1));
    step();
    rd_en = 4'b1000; step();
    rd_en = '0; step(); idle_in();
    rd_en = 4'hF; step(); idle_in();
    for (int c = 0; c < NC; c++)
      chk($sformatf("bcast_head%0d", c), dout_w[0][c*W +: W], W'(64'h77));
    chk("bcast_ptr_model", W'(nr[0]), W'(1));

    // Same-cycle push and pop on a one-item channel, then pop on empty.
    addr_en = 1; addr = 0; wr_en = 1; din = 64'h99; rd_en = 4'b0001; step(); idle_in();
    chk("pushpop_head", dout_w[0][0 +: W], W'(64'h99));
    rd_en = 4'b0001; step(); step(); idle_in();
    chk("pop_empty", W'(empty_w[0][0]), W'(1'b1));

    // Reset with items queued discards them and rewinds next_r.
    for (int i = 0; i < 6; i++) begin
      din = W'(64'hC0 + i); wr_en = 1; step();
    end
    rst = 1'b1; m_reset(); #1;
    chk("midrst_empty", W'(empty_w[0]), W'(4'b1111));
    chk("midrst_idle", W'(idle_w[0]), W'(1'b1));
    step(); step();
    rst = 1'b0; idle_in(); step();
    din = 64'hE0; wr_en = 1; step(); idle_in();
    chk("post_rst_ch0", dout_w[0][0 +: W], W'(64'hE0));

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1; m_reset();
      end else begin
        rst = 1'b0;
      end
      din     = {$urandom, $urandom};
      wr_en   = ($urandom_range(0, 2) != 0);
      bcast   = ($urandom_range(0, 7) == 0);
      addr_en = ($urandom_range(0, 3) == 0);
      addr    = 2'($urandom_range(0, 3));
      rd_en   = NC'($urandom & $urandom);
      step();
    end
    rst = 1'b0; idle_in(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
